// File: rtl/clock_disp_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment scanner with frame snapshot and field blink.
// Optional LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module clock_disp_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] min_l,
    input  logic [3:0] min_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] hour_h,
    input  logic [1:0] blink_sel,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       frame_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [BW-1:0] r_bcnt;
    logic          r_hide;
    logic          r_pend;
    logic [23:0]   r_snap;

    logic          w_term;
    logic          w_fend;
    logic          w_load;
    logic [3:0]    w_digit;
    logic          w_fld;
    logic          w_lz;
    logic [6:0]    w_seg;
    logic [5:0]    w_an;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_term  = (r_cnt == CNT_LAST);
        w_fend  = w_term && (r_idx == 3'd5);
        w_load  = r_pend || w_fend;
        w_digit = 4'd0;
        w_fld   = 1'b0;
        case (r_idx)
            3'd0:    w_digit = r_snap[3:0];
            3'd1:    w_digit = r_snap[7:4];
            3'd2:    w_digit = r_snap[11:8];
            3'd3:    w_digit = r_snap[15:12];
            3'd4:    w_digit = r_snap[19:16];
            3'd5:    w_digit = r_snap[23:20];
            default: w_digit = 4'd0;
        endcase
        // Field membership: sec = idx 0/1, min = 2/3, hour = 4/5
        case (blink_sel)
            2'b01:   w_fld = (r_idx == 3'd0) || (r_idx == 3'd1);
            2'b10:   w_fld = (r_idx == 3'd2) || (r_idx == 3'd3);
            2'b11:   w_fld = (r_idx == 3'd4) || (r_idx == 3'd5);
            default: w_fld = 1'b0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        w_lz = (r_idx == 3'd5) && (r_snap[23:20] == 4'd0);
`else
        w_lz = 1'b0;
`endif
        w_an  = 6'b000001 << r_idx;
        w_seg = ((r_hide && w_fld) || w_lz) ? 7'b0000000 : decode(w_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_bcnt  <= '0;
            r_hide  <= 1'b0;
            r_pend  <= 1'b1;
            r_snap  <= '0;
            an_o    <= 6'b0;
            seg_o   <= 7'b0;
            frame_o <= 1'b0;
        end else begin
            r_pend  <= 1'b0;
            frame_o <= w_load;
            an_o    <= w_an;
            seg_o   <= w_seg;
            if (w_term) begin
                r_cnt <= '0;
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load)
                r_snap <= {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
            // Disabled blink parks in the visible phase for a clean restart
            if (blink_sel == 2'b00) begin
                r_bcnt <= '0;
                r_hide <= 1'b0;
            end else if (w_fend) begin
                if (r_bcnt == BLK_LAST) begin
                    r_bcnt <= '0;
                    r_hide <= ~r_hide;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed bench for clock_disp_scan with SCAN_DIV=4, BLINK_DIV=2.
// Expected segment patterns are hand-derived per frame slot.
module tb_clock_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic [1:0] blink_sel;
    logic [5:0] an_o;
    logic [6:0] seg_o;
    logic       frame_o;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] BL = 7'b0000000;

    int n_chk  = 0;
    int n_fail = 0;

    clock_disp_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sec_l    (sec_l),
        .sec_h    (sec_h),
        .min_l    (min_l),
        .min_h    (min_h),
        .hour_l   (hour_l),
        .hour_h   (hour_h),
        .blink_sel(blink_sel),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slot order: d0 = sec_l ... d5 = hour_h
    function automatic logic [41:0] fr(input logic [6:0] d5, d4, d3,
                                       input logic [6:0] d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic set_time(input logic [3:0] hh, hl, mh, ml, sh, sl);
        hour_h = hh; hour_l = hl; min_h = mh;
        min_l  = ml; sec_h  = sh; sec_l = sl;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("frame_timeout", frame_o, 1);
    endtask

    // Checks one full frame; returns on the negedge of the next frame pulse
    task automatic check_frame(input string tag, input logic [41:0] e,
                               input logic chg, input logic [3:0] n_sl,
                               input logic [3:0] n_hl);
        int k;
        wait_frame();
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            k = (t - 1) / 4;
            chk({tag, "_an"}, an_o, 6'b000001 << k);
            chk({tag, "_seg"}, seg_o, e[k*7 +: 7]);
            chk({tag, "_frm"}, frame_o, (t == 24));
            if (chg && t == 12) begin
                sec_l  = n_sl;
                hour_l = n_hl;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [41:0] f1, f2, fz;

    initial begin
        f1 = fr(S1, S2, S3, S4, S5, S6);
        f2 = fr(S1, S2, S3, S4, S5, S7);
        rst = 1'b1;
        blink_sel = 2'b00;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", an_o, 0);
        chk("rst_seg", seg_o, 0);
        chk("rst_frm", frame_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_frm", frame_o, 1);
        chk("first_an", an_o, 6'b000001);
        @(negedge clk);
        chk("first_frm_drop", frame_o, 0);

        check_frame("s1a", f1, 1'b0, 4'd0, 4'd0);
        check_frame("s1b", f1, 1'b0, 4'd0, 4'd0);

        check_frame("s2a", f1, 1'b1, 4'd7, 4'd9);
        check_frame("s2b", fr(S1, S9, S3, S4, S5, S7), 1'b1, 4'd7, 4'd2);
        check_frame("s2c", f2, 1'b0, 4'd0, 4'd0);

        fz = fr(S1, S2, BL, BL, S5, S7);
        blink_sel = 2'b10;
        check_frame("s3a", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s3b", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s3c", fz, 1'b0, 4'd0, 4'd0);
        check_frame("s3d", fz, 1'b0, 4'd0, 4'd0);
        check_frame("s3e", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s3f", f2, 1'b0, 4'd0, 4'd0);
        blink_sel = 2'b00;
        check_frame("s3g", f2, 1'b0, 4'd0, 4'd0);
        blink_sel = 2'b01;
        check_frame("s3h", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s3i", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s3j", fr(S1, S2, S3, S4, BL, BL), 1'b0, 4'd0, 4'd0);
        blink_sel = 2'b00;
        check_frame("s3k", f2, 1'b0, 4'd0, 4'd0);

        hour_h = 4'hB;
        check_frame("s4a", f2, 1'b0, 4'd0, 4'd0);
        check_frame("s4b", fr(BL, S2, S3, S4, S5, S7), 1'b0, 4'd0, 4'd0);
        hour_h = 4'd1;
        check_frame("s4c", fr(BL, S2, S3, S4, S5, S7), 1'b0, 4'd0, 4'd0);

        repeat (17) @(negedge clk);
        chk("s5_pre_an", an_o, 6'b010000);
        rst = 1'b1;
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'd8);
        @(negedge clk);
        chk("s5_rst_an", an_o, 0);
        chk("s5_rst_seg", seg_o, 0);
        chk("s5_rst_frm", frame_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("s5_frm", frame_o, 1);
        chk("s5_an0", an_o, 6'b000001);
        chk("s5_seg0", seg_o, S0);
        repeat (3) begin
            @(negedge clk);
            chk("s5_an", an_o, 6'b000001);
            chk("s5_seg", seg_o, S8);
        end
        @(negedge clk);
        chk("s5_an1", an_o, 6'b000010);
        chk("s5_seg1", seg_o, S4);
        check_frame("s5", fr(S2, S3, S5, S9, S4, S8), 1'b0, 4'd0, 4'd0);

        set_time(4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
        check_frame("s6a", fr(S2, S3, S5, S9, S4, S8), 1'b0, 4'd0, 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("s6b", fr(BL, S7, S0, S0, S0, S0), 1'b0, 4'd0, 4'd0);
`else
        check_frame("s6b", fr(S0, S7, S0, S0, S0, S0), 1'b0, 4'd0, 4'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
